// File: rtl/blake2_pkg.sv
// blake2_pkg: shared constants and state type for the BLAKE2s message sequencer
package blake2_pkg;
    localparam int BB         = 64;
    localparam int NN_MAX     = 32;
    localparam int NN_DEFAULT = 32;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_WAIT, S_OUT} state_t;
endpackage

// File: rtl/blake2_digest_tap.sv
// blake2_digest_tap: counts nn digest bytes off the core from the start pulse and forwards them registered
module blake2_digest_tap (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [5:0] nn,
    input  logic [7:0] h,
    output logic       valid,
    output logic [7:0] data,
    output logic       last
);
    logic       active;
    logic       fire;
    logic       end_b;
    logic [5:0] oc;
    logic [5:0] cnt;
    assign fire  = start | active;
    assign cnt   = start ? '0 : oc;
    assign end_b = cnt == nn - 6'd1;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            active <= 1'b0;
            oc     <= '0;
            valid  <= 1'b0;
            data   <= '0;
            last   <= 1'b0;
        end else begin
            valid  <= fire;
            data   <= fire ? h : '0;
            last   <= fire & end_b;
            oc     <= fire ? cnt + 6'd1 : oc;
            active <= fire & ~end_b;
        end
    end
endmodule

// File: rtl/blake2s_msg_ctrl.sv
// blake2s_msg_ctrl: frames a byte stream into zero-padded 64-byte blocks for the blake2s core and returns the digest
module blake2s_msg_ctrl #(
    parameter int BB     = blake2_pkg::BB,
    parameter int NN_MAX = blake2_pkg::NN_MAX
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [63:0]           cmd_ll_i,
    input  logic [5:0]            cmd_nn_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [7:0]            in_data_i,
    output logic                  out_valid_o,
    output logic [7:0]            out_data_o,
    output logic                  out_last_o,
    output logic [7:0]            core_kk_o,
    output logic [7:0]            core_nn_o,
    output logic [63:0]           core_ll_o,
    output logic                  core_first_o,
    output logic                  core_last_o,
    output logic                  core_data_v_o,
    output logic [$clog2(BB)-1:0] core_idx_o,
    output logic [7:0]            core_data_o,
    input  logic                  core_finished_i,
    input  logic [7:0]            core_h_i
);
    import blake2_pkg::*;
    localparam int IW = $clog2(BB);
    state_t        state;
    logic [63:0]   rem;
    logic [IW-1:0] idx;
    logic          first;
    logic          last;
    logic [5:0]    nn_q;
    logic [5:0]    nn_c;
    logic          cmd_fire;
    logic          in_fire;
    logic          idx_end;
    logic          tap_start;
    assign cmd_ready_o  = state == S_IDLE;
    assign in_ready_o   = state == S_LOAD;
    assign cmd_fire     = cmd_valid_i & cmd_ready_o;
    assign in_fire      = in_valid_i & in_ready_o;
    assign idx_end      = idx == IW'(BB - 1);
    assign tap_start    = (state == S_WAIT) & core_finished_i & last;
    assign nn_c         = (cmd_nn_i == '0 || cmd_nn_i > 6'(NN_MAX)) ? 6'(NN_MAX) : cmd_nn_i;
    assign core_kk_o    = '0;
    assign core_nn_o    = {2'b00, nn_q};
    assign core_first_o = first;
    assign core_last_o  = last;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= S_IDLE;
            rem           <= '0;
            idx           <= '0;
            first         <= 1'b0;
            last          <= 1'b0;
            nn_q          <= 6'(NN_DEFAULT);
            core_ll_o     <= '0;
            core_data_v_o <= 1'b0;
            core_idx_o    <= '0;
            core_data_o   <= '0;
        end else begin
            core_data_v_o <= 1'b0;
            case (state)
                S_IDLE: if (cmd_fire) begin
                    core_ll_o <= cmd_ll_i;
                    nn_q      <= nn_c;
                    rem       <= cmd_ll_i;
                    idx       <= '0;
                    first     <= 1'b1;
                    last      <= cmd_ll_i <= 64'(BB);
                    state     <= cmd_ll_i != '0 ? S_LOAD : S_PAD;
                end
                // a block wrap wins over end-of-message so exact multiples of 64 skip PAD
                S_LOAD: if (in_fire) begin
                    core_data_v_o <= 1'b1;
                    core_idx_o    <= idx;
                    core_data_o   <= in_data_i;
                    idx           <= idx + IW'(1);
                    rem           <= rem - 64'd1;
                    state         <= idx_end ? S_WAIT : rem == 64'd1 ? S_PAD : S_LOAD;
                end
                S_PAD: begin
                    core_data_v_o <= 1'b1;
                    core_idx_o    <= idx;
                    core_data_o   <= '0;
                    idx           <= idx + IW'(1);
                    state         <= idx_end ? S_WAIT : S_PAD;
                end
                S_WAIT: if (core_finished_i) begin
                    first <= 1'b0;
                    last  <= ~last & (rem <= 64'(BB));
                    idx   <= '0;
                    state <= last ? S_OUT : S_LOAD;
                end
                S_OUT: state <= out_last_o ? S_IDLE : S_OUT;
                default: state <= S_IDLE;
            endcase
        end
    end
    blake2_digest_tap u_tap (
        .clk    (clk),
        .nreset (nreset),
        .start  (tap_start),
        .nn     (nn_q),
        .h      (core_h_i),
        .valid  (out_valid_o),
        .data   (out_data_o),
        .last   (out_last_o)
    );
endmodule

// File: tb/tb_blake2s_msg_ctrl.sv
// tb_blake2s_msg_ctrl: random-message bench with a behavioural core stand-in and block-level reference model
module tb_blake2s_msg_ctrl;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [63:0] cmd_ll_i = '0;
    logic [5:0]  cmd_nn_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_data_i = '0;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic [7:0]  core_kk_o;
    logic [7:0]  core_nn_o;
    logic [63:0] core_ll_o;
    logic        core_first_o;
    logic        core_last_o;
    logic        core_data_v_o;
    logic [5:0]  core_idx_o;
    logic [7:0]  core_data_o;
    logic        core_finished_i;
    logic [7:0]  core_h_i;

    typedef struct {int cyc; logic f; logic l; logic [5:0] idx; logic [7:0] d; logic [63:0] ll;} wr_t;
    typedef struct {int cyc; logic [7:0] d; logic l;} ob_t;
    wr_t wq[$];
    ob_t oq[$];
    logic [7:0]   msg [0:255];
    logic [7:0]   dig [0:31];
    logic [255:0] abc = 256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982;
    int cyc = 0;
    int fin_cyc = 0;
    int wtotal = 0;
    int served = 0;
    int checks = 0;
    int errors = 0;

    blake2s_msg_ctrl dut (
        .clk             (clk),
        .nreset          (nreset),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_ll_i        (cmd_ll_i),
        .cmd_nn_i        (cmd_nn_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .out_valid_o     (out_valid_o),
        .out_data_o      (out_data_o),
        .out_last_o      (out_last_o),
        .core_kk_o       (core_kk_o),
        .core_nn_o       (core_nn_o),
        .core_ll_o       (core_ll_o),
        .core_first_o    (core_first_o),
        .core_last_o     (core_last_o),
        .core_data_v_o   (core_data_v_o),
        .core_idx_o      (core_idx_o),
        .core_data_o     (core_data_o),
        .core_finished_i (core_finished_i),
        .core_h_i        (core_h_i)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core stand-in: logs writes and output bytes, pulses finished after every 64 writes, then streams dig[k] k cycles later
    initial begin
        int hk;
        int dly;
        bit pend;
        hk = 32;
        dly = 0;
        pend = 0;
        core_finished_i = 1'b0;
        core_h_i = '0;
        forever begin
            @(negedge clk);
            if (core_data_v_o) begin
                wq.push_back('{cyc, core_first_o, core_last_o, core_idx_o, core_data_o, core_ll_o});
                wtotal++;
            end
            if (out_valid_o) oq.push_back('{cyc, out_data_o, out_last_o});
            core_finished_i = 1'b0;
            if (!nreset) begin
                served = wtotal;
                pend = 0;
                hk = 32;
                core_h_i = '0;
            end else begin
                if (hk < 32) begin
                    core_h_i = dig[hk];
                    hk++;
                end
                if (pend) begin
                    if (dly == 0) begin
                        core_finished_i = 1'b1;
                        fin_cyc = cyc;
                        core_h_i = dig[0];
                        hk = 1;
                        pend = 0;
                    end else dly--;
                end else if (wtotal - served >= 64) begin
                    served += 64;
                    pend = 1;
                    dly = $urandom_range(0, 3);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_in_ready"}, in_ready_o, 0);
        check({tag, "_out"}, {out_valid_o, out_last_o, out_data_o}, 0);
        check({tag, "_core_wr"}, {core_data_v_o, core_first_o, core_last_o, core_idx_o, core_data_o}, 0);
        check({tag, "_core_kk"}, core_kk_o, 0);
        check({tag, "_core_nn"}, core_nn_o, 32);
        check({tag, "_core_ll"}, core_ll_o, 0);
    endtask

    task automatic send_cmd(input int ll, input logic [5:0] nn, output int acc);
        int t;
        t = 0;
        while (!cmd_ready_o && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_ll_i = 64'(ll);
        cmd_nn_i = nn;
        acc = cyc;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps, output int taken);
        int t;
        bit hs;
        taken = 0;
        t = 0;
        while (taken < n && t < 5000) begin
            in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data_i = msg[taken];
            @(negedge clk);
            hs = in_valid_i && in_ready_o;
            @(posedge clk);
            #1;
            if (hs) taken++;
            t++;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic run(input int ll, input logic [5:0] nn, input bit gaps, input bit use_abc);
        int nne, nb, acc, taken, t, b, o;
        nne = (nn == 0 || nn > 32) ? 32 : int'(nn);
        nb = ll == 0 ? 1 : (ll + 63) / 64;
        for (int k = 0; k < ll; k++) msg[k] = use_abc ? 8'h61 + 8'(k) : 8'($urandom);
        for (int k = 0; k < 32; k++) dig[k] = use_abc ? abc[255-8*k -: 8] : 8'($urandom);
        wq.delete();
        oq.delete();
        send_cmd(ll, nn, acc);
        feed(ll, gaps, taken);
        check("bytes_taken", taken, ll);
        t = 0;
        while (!(oq.size() > 0 && oq[oq.size()-1].l) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("out_last_seen", t < 5000, 1);
        check("ready_during_last", cmd_ready_o, 0);
        @(posedge clk);
        #1;
        check("ready_after_last", cmd_ready_o, 1);
        check("n_writes", wq.size(), nb * 64);
        if (!gaps && wq.size() > 0) check("first_write_lat", wq[0].cyc - acc, 2);
        for (int j = 0; j < wq.size() && j < nb * 64; j++) begin
            b = j / 64;
            o = j % 64;
            check("write", {wq[j].f, wq[j].l, wq[j].idx, wq[j].d},
                  {b == 0, b == nb - 1, 6'(o), j < ll ? msg[j] : 8'h00});
            if (o == 0) check("core_ll", wq[j].ll, ll);
            if (o == 63 && !gaps) check("block_span", wq[j].cyc - wq[j-63].cyc, 63);
        end
        check("n_out", oq.size(), nne);
        for (int k = 0; k < oq.size() && k < nne; k++) begin
            check("out_byte", {oq[k].l, oq[k].d}, {k == nne - 1, dig[k]});
            check("out_cyc", oq[k].cyc - fin_cyc, k + 1);
        end
    endtask

    initial begin
        int acc, taken;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        nreset = 1'b1;
        @(posedge clk);
        #1;
        run(0, 6'd32, 0, 0);
        run(3, 6'd32, 0, 1);
        run(64, 6'd32, 0, 0);
        run(65, 6'd20, 0, 0);
        run(130, 6'd16, 1, 0);
        run(128, 6'd0, 0, 0);
        run(10, 6'd45, 1, 0);
        run(1, 6'd1, 0, 0);
        for (int r = 0; r < 4; r++) run($urandom_range(0, 200), 6'($urandom), 1'($urandom_range(0, 1)), 0);
        // abandon a block part-way through, then prove a fresh command still works
        for (int k = 0; k < 200; k++) msg[k] = 8'($urandom);
        send_cmd(200, 6'd32, acc);
        feed(20, 0, taken);
        check("mid_taken", taken, 20);
        nreset = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        run(3, 6'd32, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blake2s_msg_ctrl.md
# blake2s_msg_ctrl

Message sequencer in front of the `blake2s_hash256` core. It accepts a hash command (message length, digest length) and an unframed byte stream. It then:
- cuts the stream into 64-byte blocks,
- zero-pads the final block,
- drives `block_first_i`, `block_last_i`, `data_idx_i` and `ll_i` into the core,
- captures the digest bytes the core streams out after the last compression.

It is the only master of the core's input port. Keys are not supported, so `kk_i` is tied to 0.

## Interface
Parameters:
- `BB`, 64: block bytes (fixed for BLAKE2s; sets the 6-bit index width).
- `NN_MAX`, 32: largest digest length in bytes.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  high only in IDLE.
- `cmd_ll_i`  in  64  message length in bytes (0 allowed).
- `cmd_nn_i`  in  6  digest bytes, 1..32; values outside this range are clamped to 32.
- `in_valid_i` / `in_ready_o`  in / out  1 each  message byte handshake.
- `in_data_i`  in  8  message byte.
- `out_valid_o`  out  1  digest byte strobe; there is no backpressure.
- `out_data_o`  out  8  digest byte.
- `out_last_o`  out  1  marks the final digest byte.
- `core_kk_o`  out  8  constant 0.
- `core_nn_o`  out  8  latched nn.
- `core_ll_o`  out  64  latched ll.
- `core_first_o` / `core_last_o`  out  1 each  block_first_i / block_last_i.
- `core_data_v_o`  out  1  to data_v_i.
- `core_idx_o`  out  6  to data_idx_i.
- `core_data_o`  out  8  to data_i.
- `core_finished_i`  in  1  from finished_o.
- `core_h_i`  in  8  from h_o.

## Operation
State machine states: IDLE, LOAD, PAD, WAIT, OUT.

- **IDLE**
  - On `cmd_valid_i & cmd_ready_o`: latch ll and nn; set `rem` = ll (64-bit), `idx` = 0, `first` = 1.
  - Go to LOAD if ll != 0; otherwise go to PAD.
- **Block flag**
  - `last` = (`rem` <= 64), evaluated at block start and registered.
  - `core_first_o` and `core_last_o` are held stable from the first byte of a block until `core_finished_i` for that block.
- **LOAD**
  - `in_ready_o` = 1.
  - Each handshake drives `core_data_v_o` = 1, `core_idx_o` = `idx`, `core_data_o` = `in_data_i` (registered, one cycle later), then increments `idx` and decrements `rem`.
  - When `idx` wraps 63 -> 0, go to WAIT.
  - When `rem` reaches 0 with `idx` != 0, go to PAD.
- **PAD**
  - No input accepted.
  - Writes byte 0x00 at `idx`, `idx`+1, ... 63, one byte per cycle, then goes to WAIT.
  - For ll=0, PAD writes all 64 zero bytes with first = last = 1.
- **WAIT**
  - No input accepted.
  - On `core_finished_i`: clear `first`.
  - If `last`, go to OUT. Otherwise return to LOAD with `idx` = 0.
- **OUT**
  - The core presents digest byte k on `core_h_i` k cycles after its finished pulse (byte 0 appears in the finished cycle itself). The capture counter `oc` starts in that cycle.
  - Each byte is forwarded registered as `out_data_o` with `out_valid_o` = 1, for nn cycles.
  - `out_last_o` accompanies byte nn-1.
  - Then return to IDLE.
- **Width rules**
  - `rem` is 64-bit and never underflows.
  - `idx` is 6-bit modulo 64.
  - `oc` is 6-bit.
- **Ignored events**
  - `core_finished_i` outside WAIT is ignored.
  - `cmd_valid_i` outside IDLE is ignored.

## Timing
- **Reset values**
  - State IDLE.
  - `cmd_ready_o` = 1.
  - All other outputs 0, except `core_nn_o` = 32.
- **Reset mid-operation**: asserting `nreset` at any time returns immediately to reset values. A partially loaded block is abandoned, and the core is reset by the same net.
- **Command to first core write**: 2 cycles (command accept, then first byte handshake, then registered write).
- **Load throughput**: 1 byte per cycle when `in_valid_i` is held high. Input gaps stall `idx` without emitting `core_data_v_o`.
- **Full block, no stall**: 64 consecutive `core_data_v_o` cycles.
- **Message whose length is a multiple of 64**: the last byte lands at idx 63 with `last` = 1. No extra empty block is issued.
- **Digest output**: `out_valid_o` runs for exactly nn consecutive cycles, starting 1 cycle after the final `core_finished_i`.
- **Next command**: accepted the cycle after `out_last_o`.

## Structure
- Package `blake2_pkg` holds:
  - `BB`, `NN_MAX`;
  - the state enum;
  - the BLAKE2s constant `NN_DEFAULT` = 32.
- The digest capture/forward logic is a natural sub-module, `blake2_digest_tap`: counter plus output register, with inputs start pulse, nn and byte in.
- Everything else is flat.

## Test plan
- **ll=0, nn=32**: 64 zero writes at idx 0..63 with first = last = 1. After a finished pulse, 32 out bytes are emitted, with `out_last_o` on the 32nd.
- **"abc" (ll=3, nn=32)**: writes 61,62,63 at idx 0..2, then zeros at idx 3..63. The digest equals 508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982.
- **ll=64**: exactly one block with first = last = 1 and no PAD cycles.
- **ll=65**: block 1 has first=1, last=0. Block 2 has first=0, last=1, holds 1 data byte plus 63 zeros, and `core_ll_o` = 65 throughout.
- **ll=130 with random `in_valid_i` gaps and nn=16**: the same core writes occur as with no gaps (only spread out in time); 16 out bytes are emitted.
- **`nreset` pulse at idx 20 of a block**: all outputs return to reset values. A fresh ll=3 command then completes correctly.
